// File: rtl/mem_req_port.sv
// Per-core initiator toward the banked-memory arbiter: one load/store in flight, one-cycle response pulse.
// Latency: accept edge N, enable in N+1, arbiter ready in N+2 at the earliest, response in N+3.
// Backpressure: req_ready is low while a request is outstanding; MEM_REQ_TIMEOUT_EN adds a watchdog abort.
module mem_req_port #(
  parameter int ADDR_SIZE      = 8,
  parameter int REG_SIZE       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [REG_SIZE-1:0]  req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [REG_SIZE-1:0]  resp_data,
  output logic                 resp_err,
  output logic [1:0]           enable,
  output logic [ADDR_SIZE-1:0] addr,
  output logic [REG_SIZE-1:0]  wr_data,
  input  logic [REG_SIZE-1:0]  rd_data,
  input  logic                 ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0] state;
  logic       we_q;
  logic       accept;
  logic       complete;
  logic       abort;

  assign req_ready = (state == IDLE);
  assign accept    = (state == IDLE) && req_valid;
  assign complete  = (state == REQ) && ready;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CW-1:0] wait_cnt;

  // A ready arriving in the abort cycle takes priority, so abort requires ready low.
  assign abort = (state == REQ) && !ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_err <= abort;
      if (accept) begin
        wait_cnt <= '0;
      end else if ((state == REQ) && !ready && !abort) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign abort    = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Enable drops in the ready cycle so the arbiter cannot grant this core a second time.
  always_comb begin
    enable = 2'b00;
    if ((state == REQ) && !ready && !abort) begin
      enable = we_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (state == IDLE) begin
        if (req_valid) begin
          state   <= REQ;
          we_q    <= req_we;
          addr    <= req_addr;
          wr_data <= req_we ? req_wdata : '0;
        end
      end else begin
        if (complete) begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_data  <= we_q ? '0 : rd_data;
        end else if (abort) begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_data  <= '0;
        end
      end
    end
  end

  a_timeout_param: assert property (@(posedge clk) TIMEOUT_CYCLES > 1);

  a_enable_onehot: assert property (@(posedge clk) disable iff (reset) enable != 2'b11);

  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    ((state == REQ) && !complete && !abort) |=> ($stable(addr) && $stable(wr_data)));

  a_resp_single: assert property (@(posedge clk) disable iff (reset) resp_valid |=> !resp_valid);

endmodule

// File: tb/tb_mem_req_port.sv
// Bench for mem_req_port: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of the outstanding request.
module tb_mem_req_port;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 8;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [1:0]    enable;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          ready;

  mem_req_port #(.ADDR_SIZE(AW), .REG_SIZE(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .enable(enable), .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the one outstanding transaction, how long it has waited, and the pending response.
  bit          m_busy;
  bit          m_we;
  logic [7:0]  m_addr;
  logic [7:0]  m_wdata;
  int          m_wait;
  bit          m_rv;
  bit          m_err;
  logic [7:0]  m_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_rv    <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      m_wait  <= 0;
    end else begin
      m_rv  <= 1'b0;
      m_err <= 1'b0;
      if (m_busy) begin
        if (ready) begin
          m_rv    <= 1'b1;
          m_rdata <= m_we ? 8'h00 : rd_data;
          m_busy  <= 1'b0;
        end else if (TO_EN && m_wait == TO - 1) begin
          m_rv    <= 1'b1;
          m_err   <= 1'b1;
          m_rdata <= 8'h00;
          m_busy  <= 1'b0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (req_valid) begin
        m_busy  <= 1'b1;
        m_we    <= req_we;
        m_addr  <= req_addr;
        m_wdata <= req_wdata;
        m_wait  <= 0;
      end
    end
  end

  bit         abort_now;
  logic [1:0] exp_en;

  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      abort_now = TO_EN && m_busy && !ready && (m_wait == TO - 1);
      exp_en = (m_busy && !ready && !abort_now) ? (m_we ? 2'b10 : 2'b01) : 2'b00;
      chk("cmp_req_ready", req_ready, !m_busy);
      chk("cmp_enable", enable, exp_en);
      if (m_busy) begin
        chk("cmp_addr", addr, m_addr);
        chk("cmp_wr_data", wr_data, m_we ? m_wdata : 8'h00);
      end
      chk("cmp_resp_valid", resp_valid, m_rv);
      if (m_rv) begin
        chk("cmp_resp_data", resp_data, m_rdata);
        chk("cmp_resp_err", resp_err, m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rd_data   = '0;
    ready     = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  int rdy_pct;

  initial begin
    reset = 1'b1;
    quiet_inputs();
    step();
    step();
    @(negedge clk);
    chk("rst_enable", enable, 2'b00);
    chk("rst_addr", addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_resp_err", resp_err, 1'b0);
    step();
    reset   = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);

    // Load served on the first arbitration cycle.
    step();
    issue(1'b0, 8'h35, 8'hEE);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("ld_enable_c1", enable, 2'b01);
    chk("ld_addr_c1", addr, 8'h35);
    chk("ld_wr_data_c1", wr_data, 8'h00);
    step();
    ready = 1'b1; rd_data = 8'hA7;
    @(negedge clk);
    chk("ld_enable_c2", enable, 2'b00);
    step();
    ready = 1'b0; rd_data = 8'h00;
    @(negedge clk);
    chk("ld_resp_valid_c3", resp_valid, 1'b1);
    chk("ld_resp_data_c3", resp_data, 8'hA7);
    chk("ld_req_ready_c3", req_ready, 1'b1);

    // Store with a four-cycle arbitration wait.
    step();
    issue(1'b1, 8'h12, 8'h5C);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_enable_wait", enable, 2'b10);
      chk("st_wr_data_wait", wr_data, 8'h5C);
      chk("st_addr_wait", addr, 8'h12);
      chk("st_no_resp_wait", resp_valid, 1'b0);
      step();
    end
    ready = 1'b1; rd_data = 8'hFF;
    @(negedge clk);
    chk("st_enable_ready", enable, 2'b00);
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("st_resp_valid", resp_valid, 1'b1);
    chk("st_resp_data", resp_data, 8'h00);
    chk("st_enable_after", enable, 2'b00);
    step();
    @(negedge clk);
    chk("st_single_resp", resp_valid, 1'b0);

    // Back-to-back: store accepted in the load's response cycle.
    issue(1'b0, 8'h01, 8'h00);
    step();
    req_valid = 1'b0;
    step();
    ready = 1'b1; rd_data = 8'h3C;
    step();
    ready = 1'b0;
    issue(1'b1, 8'h02, 8'h99);
    @(negedge clk);
    chk("b2b_resp1_valid", resp_valid, 1'b1);
    chk("b2b_resp1_data", resp_data, 8'h3C);
    chk("b2b_req_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_st_enable", enable, 2'b10);
    chk("b2b_st_addr", addr, 8'h02);
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("b2b_resp2_valid", resp_valid, 1'b1);
    chk("b2b_resp2_data", resp_data, 8'h00);

    // Spurious ready in IDLE, then req_valid toggling during REQ.
    step();
    ready = 1'b1; rd_data = 8'h77;
    step();
    @(negedge clk);
    chk("spur_no_resp1", resp_valid, 1'b0);
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("spur_no_resp2", resp_valid, 1'b0);
    issue(1'b0, 8'h44, 8'h00);
    step();
    for (int i = 0; i < 4; i++) begin
      req_valid = ~req_valid;
      req_we    = 1'b1;
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      @(negedge clk);
      chk("mid_addr_hold", addr, 8'h44);
      chk("mid_wr_data_hold", wr_data, 8'h00);
      chk("mid_enable", enable, 2'b01);
      step();
    end
    req_valid = 1'b0;
    ready = 1'b1; rd_data = 8'h5A;
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("mid_resp_data", resp_data, 8'h5A);

    // Reset while a load is waiting.
    step();
    issue(1'b0, 8'h66, 8'h00);
    step();
    req_valid = 1'b0;
    chk("rreq_enable_before", enable, 2'b01);
    #2;
    reset = 1'b1;
    #1;
    chk("rreq_enable_async", enable, 2'b00);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rreq_req_ready", req_ready, 1'b1);
    chk("rreq_no_resp1", resp_valid, 1'b0);
    step();
    @(negedge clk);
    chk("rreq_no_resp2", resp_valid, 1'b0);

    // Long wait: abort at the watchdog limit, or indefinite hold without it.
    step();
    issue(1'b0, 8'h21, 8'h00);
    step();
    req_valid = 1'b0;
    for (int c = 1; c < TO; c++) begin
      @(negedge clk);
      chk("wait_enable", enable, 2'b01);
      step();
    end
`ifdef MEM_REQ_TIMEOUT_EN
    @(negedge clk);
    chk("to_enable_abort", enable, 2'b00);
    chk("to_req_ready_abort", req_ready, 1'b0);
    step();
    @(negedge clk);
    chk("to_resp_valid", resp_valid, 1'b1);
    chk("to_resp_err", resp_err, 1'b1);
    chk("to_resp_data", resp_data, 8'h00);
    chk("to_req_ready", req_ready, 1'b1);
    step();
    @(negedge clk);
    chk("to_enable_after", enable, 2'b00);
    // Ready in the abort cycle completes normally.
    issue(1'b0, 8'h22, 8'h00);
    step();
    req_valid = 1'b0;
    for (int c = 1; c < TO; c++) step();
    ready = 1'b1; rd_data = 8'hC3;
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("to_race_resp_valid", resp_valid, 1'b1);
    chk("to_race_resp_err", resp_err, 1'b0);
    chk("to_race_resp_data", resp_data, 8'hC3);
`else
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("hold_enable", enable, 2'b01);
      chk("hold_no_resp", resp_valid, 1'b0);
      step();
    end
    ready = 1'b1; rd_data = 8'hC3;
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("hold_resp_valid", resp_valid, 1'b1);
    chk("hold_resp_err", resp_err, 1'b0);
    chk("hold_resp_data", resp_data, 8'hC3);
`endif

    // Randomized traffic with varying arbiter congestion.
    rdy_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i % 200 == 0) rdy_pct = $urandom_range(3, 70);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      rd_data   = 8'($urandom);
      ready     = ($urandom_range(0, 99) < rdy_pct);
    end

    step();
    quiet_inputs();
    step();
    step();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
